// File: rtl/dram_responder_if.sv
// Request/response bundle between the fetch unit (master) and the byte DRAM responder (slave).
interface dram_responder_if;
  logic [7:0]        req_en;
  logic              req_rdwr;
  logic [7:0][7:0]   req_wdata;
  logic [7:0][63:0]  req_addr;
  logic [7:0]        rsp_valid;
  logic [7:0]        rsp_err;
  logic [7:0][7:0]   rsp_rdata;
  logic              busy;

  modport master (
    output req_en, req_rdwr, req_wdata, req_addr,
    input  rsp_valid, rsp_err, rsp_rdata, busy
  );

  modport slave (
    input  req_en, req_rdwr, req_wdata, req_addr,
    output rsp_valid, rsp_err, rsp_rdata, busy
  );
endinterface

// File: rtl/dram_responder.sv
// Byte-array responder: latches an 8-lane read/write batch, serves enabled lanes
// lowest-first one per cycle, then pulses rsp_valid with the batch mask.
module dram_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned EXTRA_LAT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  dram_responder_if.slave      bus,
  input  logic                 ld_en,
  input  logic [ADDR_BITS-1:0] ld_addr,
  input  logic [7:0]           ld_data
);

  localparam int unsigned LANES  = 8;
  localparam int unsigned LANE_W = 3;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] LAT_LOAD = (EXTRA_LAT > 0) ? CNT_W'(EXTRA_LAT - 1) : '0;

  typedef enum logic [1:0] {IDLE, SERVE, WAIT, DONE} state_t;

  state_t                   state;
  logic [LANES-1:0]         mask;
  logic [LANES-1:0]         pending;
  logic [LANES-1:0]         err;
  logic                     rdwr;
  logic [LANES-1:0][63:0]   addr;
  logic [LANES-1:0][7:0]    wdata;
  logic [CNT_W-1:0]         cnt;
  logic [LANES-1:0]         rsp_valid;
  logic [LANES-1:0]         rsp_err;
  logic [LANES-1:0][7:0]    rsp_rdata;
  logic                     busy;

  logic [7:0]               mem [DEPTH];

  logic [LANE_W-1:0]        lane_c;
  logic [LANES-1:0]         lane_bit_c;
  logic [63:0]              lane_addr_c;
  logic                     in_range_c;
  logic [ADDR_BITS-1:0]     mem_idx_c;
  logic [7:0]               rd_byte_c;
  logic                     last_c;
  logic [LANES-1:0]         err_nxt_c;
  logic                     mem_we_c;
  logic [ADDR_BITS-1:0]     mem_waddr_c;
  logic [7:0]               mem_wdata_c;

  // Current lane selection and the single shared array port (preload or lane write).
  always_comb begin
    lane_c = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (pending[i]) lane_c = LANE_W'(i);
    end
    lane_bit_c  = LANES'(1) << lane_c;
    lane_addr_c = addr[lane_c];
    in_range_c  = (lane_addr_c[63:ADDR_BITS] == '0);
    mem_idx_c   = lane_addr_c[ADDR_BITS-1:0];
    rd_byte_c   = in_range_c ? mem[mem_idx_c] : 8'h00;
    last_c      = ((pending & ~lane_bit_c) == '0);
    err_nxt_c   = in_range_c ? err : (err | lane_bit_c);

    mem_we_c    = 1'b0;
    mem_waddr_c = ld_addr;
    mem_wdata_c = ld_data;
    if (!reset) begin
      if (state == IDLE && ld_en) begin
        mem_we_c = 1'b1;
      end else if (state == SERVE && rdwr && in_range_c) begin
        mem_we_c    = 1'b1;
        mem_waddr_c = mem_idx_c;
        mem_wdata_c = wdata[lane_c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mask      <= '0;
      pending   <= '0;
      err       <= '0;
      rdwr      <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      cnt       <= '0;
      rsp_valid <= '0;
      rsp_err   <= '0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Preload wins; a held request is picked up once ld_en drops.
          if (!ld_en && bus.req_en != '0) begin
            mask    <= bus.req_en;
            pending <= bus.req_en;
            rdwr    <= bus.req_rdwr;
            addr    <= bus.req_addr;
            wdata   <= bus.req_wdata;
            busy    <= 1'b1;
            state   <= SERVE;
          end
        end
        SERVE: begin
          pending <= pending & ~lane_bit_c;
          err     <= err_nxt_c;
          if (!rdwr) rsp_rdata[lane_c] <= rd_byte_c;
          if (last_c) begin
            if (EXTRA_LAT > 0) begin
              cnt   <= LAT_LOAD;
              state <= WAIT;
            end else begin
              rsp_valid <= mask;
              rsp_err   <= err_nxt_c;
              state     <= DONE;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_valid <= mask;
            rsp_err   <= err;
            state     <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          rsp_valid <= '0;
          rsp_err   <= '0;
          err       <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_err   = rsp_err;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.busy      = busy;

endmodule
